row_mac: RTL and testbench

Multiply-accumulate stage directly downstream of `bvb`. It pops one gathered vector value from the `bvb` output FIFO together with one matrix non-zero from the matrix value FIFO and multiplies them. Products are accumulated per matrix row. On each row-end flag it writes the row dot-product and its row index into the result FIFO. One instance runs per channel.

---
 rtl/row_mac_if.sv | 30 +++
 rtl/row_mac.sv | 148 ++++++++++++++
 tb/tb_row_mac.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_mac_if.sv
// row_mac_if: FIFO-side bundle of row_mac. It carries the vector FIFO read
// port, the matrix FIFO read port and the result FIFO write port.
// The master side is the MAC. The slave side is the surrounding FIFOs.
interface row_mac_if #(
  parameter int val_bits = 16,
  parameter int acc_bits = 40,
  parameter int row_bits = 16
);
  logic [val_bits-1:0] vec;
  logic                vec_fifo_empty;
  logic                vec_fifo_read;
  logic [val_bits-1:0] mat_val;
  logic                mat_last;
  logic                mat_fifo_empty;
  logic                mat_fifo_read;
  logic [acc_bits-1:0] res;
  logic [row_bits-1:0] res_row;
  logic                res_wr_en;
  logic                res_fifo_full;

  modport master (
    input  vec, vec_fifo_empty, mat_val, mat_last, mat_fifo_empty, res_fifo_full,
    output vec_fifo_read, mat_fifo_read, res, res_row, res_wr_en
  );

  modport slave (
    output vec, vec_fifo_empty, mat_val, mat_last, mat_fifo_empty, res_fifo_full,
    input  vec_fifo_read, mat_fifo_read, res, res_row, res_wr_en
  );
endinterface

// File: rtl/row_mac.sv
// row_mac: per-channel multiply-accumulate stage behind bvb.
// It pops one vector value and one matrix non-zero together, multiplies them
// as signed numbers and accumulates the products per row. At each row end it
// writes the dot-product and the row index to the result FIFO.
// Optional feature: define ROW_MAC_SAT_EN to get a saturating accumulator.
// With the macro undefined, accumulation wraps modulo 2^acc_bits.
module row_mac #(
  parameter int channel_num = 0,
  parameter int val_bits    = 16,
  parameter int acc_bits    = 40,
  parameter int row_bits    = 16
) (
  input  logic      clk,
  input  logic      rst,
  row_mac_if.master bus
);

  localparam int prod_bits = 2 * val_bits;

  logic                       issue;
  logic                       s1_v;
  logic                       s2_v;
  logic                       s2_last;
  logic signed [acc_bits-1:0] s2_prod;
  logic signed [prod_bits-1:0] vec_x;
  logic signed [prod_bits-1:0] mat_x;
  logic signed [prod_bits-1:0] prod;
  logic signed [acc_bits-1:0] acc;
  logic signed [acc_bits-1:0] raw_sum;
  logic signed [acc_bits-1:0] sum;
  logic [row_bits-1:0]        row_cnt;
  logic signed [acc_bits-1:0] res_q;
  logic [row_bits-1:0]        res_row_q;
  logic                       res_wr_en_q;

  if (acc_bits < prod_bits) begin : g_acc_check
    $error("row_mac: acc_bits must be at least 2*val_bits");
  end
  if (channel_num < 0) begin : g_chan_check
    $error("row_mac: channel_num must be non-negative");
  end

  // Issue both FIFOs together when neither is empty and the result FIFO has room.
  always_comb begin
    issue = rst & ~bus.vec_fifo_empty & ~bus.mat_fifo_empty & ~bus.res_fifo_full;
  end

  assign bus.vec_fifo_read = issue;
  assign bus.mat_fifo_read = issue;

  // S1 valid. The FIFO dout registers act as the stage-1 data registers.
  // This keeps the read-to-write latency at 3 cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v <= 1'b0;
    end else begin
      s1_v <= issue;
    end
  end

  // Sign-extend the operands and form the full-width signed product.
  always_comb begin
    vec_x = {{val_bits{bus.vec[val_bits-1]}}, bus.vec};
    mat_x = {{val_bits{bus.mat_val[val_bits-1]}}, bus.mat_val};
    prod  = vec_x * mat_x;
  end

  // S2: register the product, widened to the accumulator, and carry the row-end flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_prod <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_last <= bus.mat_last;
        s2_prod <= acc_bits'(prod);
      end
    end
  end

  assign raw_sum = acc + s2_prod;

`ifdef ROW_MAC_SAT_EN
  localparam logic signed [acc_bits-1:0] acc_max = {1'b0, {(acc_bits-1){1'b1}}};
  localparam logic signed [acc_bits-1:0] acc_min = {1'b1, {(acc_bits-1){1'b0}}};

  logic sat;
  logic ovf;

  // Detect signed overflow and clamp the sum. Once a row has saturated, it stays clamped.
  always_comb begin
    ovf = (acc[acc_bits-1] == s2_prod[acc_bits-1]) &&
          (raw_sum[acc_bits-1] != acc[acc_bits-1]);
    if (sat) begin
      sum = acc;
    end else if (ovf) begin
      sum = acc[acc_bits-1] ? acc_min : acc_max;
    end else begin
      sum = raw_sum;
    end
  end

  // Sticky per-row saturation flag, cleared by the row-end write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat <= 1'b0;
    end else if (s2_v) begin
      sat <= s2_last ? 1'b0 : (sat | ovf);
    end
  end
`else
  // Wrapping accumulation.
  always_comb begin
    sum = raw_sum;
  end
`endif

  // S3: accumulate. At a row end, publish the sum and restart the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      row_cnt     <= '0;
      res_q       <= '0;
      res_row_q   <= '0;
      res_wr_en_q <= 1'b0;
    end else begin
      res_wr_en_q <= 1'b0;
      if (s2_v) begin
        if (s2_last) begin
          res_q       <= sum;
          res_row_q   <= row_cnt;
          res_wr_en_q <= 1'b1;
          acc         <= '0;
          row_cnt     <= row_cnt + row_bits'(1);
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign bus.res       = res_q;
  assign bus.res_row   = res_row_q;
  assign bus.res_wr_en = res_wr_en_q;

endmodule

// File: tb/tb_row_mac.sv
`timescale 1ns/1ps
// Testbench for row_mac. Directed vectors with hand-computed results drive a
// queue-backed standard (non-FWFT) FIFO model, and a monitor collects results.
// A second instance with acc_bits = 2*val_bits exercises accumulator overflow.
module tb_row_mac;
  localparam int VB  = 16;
  localparam int AB  = 40;
  localparam int RB  = 16;
  localparam int OAB = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  row_mac_if #(.val_bits(VB), .acc_bits(AB), .row_bits(RB)) bus ();
  row_mac #(.channel_num(0), .val_bits(VB), .acc_bits(AB), .row_bits(RB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  row_mac_if #(.val_bits(VB), .acc_bits(OAB), .row_bits(RB)) obus ();
  row_mac #(.channel_num(1), .val_bits(VB), .acc_bits(OAB), .row_bits(RB)) odut (
    .clk(clk), .rst(rst), .bus(obus)
  );

  // Input FIFO model: dout updates on the edge that consumes rd_en.
  logic signed [VB-1:0] vq[$];
  logic signed [VB-1:0] mq[$];
  logic                 lq[$];
  bit                   bubble_en = 1'b0;
  int unsigned          underflow = 0;

  always @(posedge clk) begin
    if (bus.vec_fifo_read === 1'b1) begin
      if (vq.size() == 0) underflow++;
      else begin
        bus.vec      <= vq.pop_front();
        bus.mat_val  <= mq.pop_front();
        bus.mat_last <= lq.pop_front();
      end
    end
    bus.vec_fifo_empty <= (vq.size() == 0) || (bubble_en && ($urandom_range(0, 1) == 1));
    bus.mat_fifo_empty <= (mq.size() == 0);
  end

  // Monitor for the main instance. Its state is cleared while reset is low.
  int unsigned cyc = 0;
  int unsigned rd_cnt, wr_cnt, bad_rd, rd_full, first_rd_cyc, last_rd_cyc;
  bit          seen_rd;
  logic signed [AB-1:0] rq[$];
  logic [RB-1:0]        rrq[$];
  int unsigned          wcq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      rd_cnt = 0; wr_cnt = 0; bad_rd = 0; rd_full = 0;
      seen_rd = 1'b0; first_rd_cyc = 0; last_rd_cyc = 0;
      rq.delete(); rrq.delete(); wcq.delete();
    end else begin
      if (bus.vec_fifo_read !== bus.mat_fifo_read) bad_rd++;
      if (bus.vec_fifo_read === 1'b1) begin
        if (bus.vec_fifo_empty !== 1'b0 || bus.mat_fifo_empty !== 1'b0) bad_rd++;
        if (bus.res_fifo_full === 1'b1) rd_full++;
        rd_cnt++;
        if (!seen_rd) first_rd_cyc = cyc;
        seen_rd = 1'b1;
        last_rd_cyc = cyc;
      end
      if (bus.res_wr_en === 1'b1) begin
        rq.push_back($signed(bus.res));
        rrq.push_back(bus.res_row);
        wcq.push_back(cyc);
        wr_cnt++;
      end
    end
  end

  // Overflow instance: constant 32767 operands, with a count of pairs available.
  int unsigned o_pushed = 0;
  int unsigned o_popped = 0;
  logic        o_last = 1'b0;
  logic signed [OAB-1:0] orq[$];

  assign obus.vec           = 16'h7FFF;
  assign obus.mat_val       = 16'h7FFF;
  assign obus.mat_last      = o_last;
  assign obus.res_fifo_full = 1'b0;

  always @(posedge clk) begin
    if (obus.vec_fifo_read === 1'b1 && o_pushed > o_popped) begin
      o_last   <= (o_pushed - o_popped == 1);
      o_popped = o_popped + 1;
    end
    obus.vec_fifo_empty <= (o_pushed == o_popped);
    obus.mat_fifo_empty <= (o_pushed == o_popped);
  end

  always @(negedge clk) if (rst && obus.res_wr_en === 1'b1) orq.push_back($signed(obus.res));

  logic signed [AB-1:0] gold [100];
  int unsigned          stream_total;

  task automatic push(input int v, input int m, input bit l);
    vq.push_back(VB'(v));
    mq.push_back(VB'(m));
    lq.push_back(l);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    bus.res_fifo_full = 1'b0;
    bubble_en = 1'b0;
    vq.delete(); mq.delete(); lq.delete();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic wait_writes(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (rq.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic load_stream();
    int len, v, m;
    stream_total = 0;
    for (int r = 0; r < 100; r++) begin
      len = (r * 5) % 8 + 1;
      gold[r] = '0;
      for (int k = 0; k < len; k++) begin
        v = ((r * 37 + k * 11) % 200) - 100;
        m = ((r * 13 + k * 29) % 300) - 150;
        push(v, m, k == len - 1);
        gold[r] = gold[r] + AB'(v * m);
        stream_total++;
      end
    end
  endtask

  task automatic test_reset();
    push(1, 1, 1);
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (bus.vec_fifo_read !== 1'b0 || bus.mat_fifo_read !== 1'b0)
      $display("FAIL reset_reads: got %b/%b expected 0/0", bus.vec_fifo_read, bus.mat_fifo_read); else n_pass++;
    n_checks++; if (bus.res !== '0 || bus.res_row !== '0 || bus.res_wr_en !== 1'b0)
      $display("FAIL reset_outputs: res=%0d row=%0d wr=%b expected 0 0 0", bus.res, bus.res_row, bus.res_wr_en); else n_pass++;
    n_checks++; if (obus.res !== '0 || obus.res_wr_en !== 1'b0)
      $display("FAIL reset_ovf_inst: res=%0d wr=%b expected 0 0", obus.res, obus.res_wr_en); else n_pass++;
  endtask

  task automatic test_single_row();
    do_reset();
    push(3, 4, 0); push(-2, 7, 0); push(5, 1, 1);
    wait_writes(1, 50);
    n_checks++; if (rq.size() !== 1) $display("FAIL single_count: got %0d expected 1", rq.size()); else n_pass++;
    n_checks++; if (rq[0] !== 40'sd3) $display("FAIL single_res: got %0d expected 3", rq[0]); else n_pass++;
    n_checks++; if (rrq[0] !== 16'd0) $display("FAIL single_row: got %0d expected 0", rrq[0]); else n_pass++;
    n_checks++; if (wcq[0] - last_rd_cyc !== 3) $display("FAIL single_latency: got %0d expected 3", wcq[0] - last_rd_cyc); else n_pass++;
    n_checks++; if (rd_cnt !== 3) $display("FAIL single_reads: got %0d expected 3", rd_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic signed [AB-1:0] exp_b2b [4];
    exp_b2b[0] = -40'sd30; exp_b2b[1] = -40'sd56; exp_b2b[2] = 40'sd10000; exp_b2b[3] = 40'sd1;
    do_reset();
    push(5, -6, 1); push(-7, 8, 1); push(100, 100, 1); push(-1, -1, 1);
    wait_writes(4, 50);
    n_checks++; if (rq.size() !== 4) $display("FAIL b2b_count: got %0d expected 4", rq.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rq[k] !== exp_b2b[k] || rrq[k] !== RB'(k))
        $display("FAIL b2b_row%0d: res=%0d row=%0d expected res=%0d row=%0d", k, rq[k], rrq[k], exp_b2b[k], k); else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (wcq[k+1] - wcq[k] !== 1)
        $display("FAIL b2b_gap%0d: got %0d cycles expected 1", k, wcq[k+1] - wcq[k]); else n_pass++;
    end
  endtask

  task automatic test_streaming();
    do_reset();
    load_stream();
    wait_writes(100, 2000);
    n_checks++; if (rq.size() !== 100) $display("FAIL stream_count: got %0d expected 100", rq.size()); else n_pass++;
    for (int r = 0; r < 100; r++) begin
      n_checks++; if (rq[r] !== gold[r] || rrq[r] !== RB'(r))
        $display("FAIL stream_row%0d: res=%0d row=%0d expected res=%0d row=%0d", r, rq[r], rrq[r], gold[r], r); else n_pass++;
    end
    n_checks++; if (rd_cnt !== stream_total || last_rd_cyc - first_rd_cyc + 1 !== stream_total)
      $display("FAIL stream_continuous: reads=%0d span=%0d expected %0d", rd_cnt, last_rd_cyc - first_rd_cyc + 1, stream_total); else n_pass++;
  endtask

  task automatic test_bubbles();
    do_reset();
    bubble_en = 1'b1;
    load_stream();
    wait_writes(100, 4000);
    bubble_en = 1'b0;
    n_checks++; if (rq.size() !== 100) $display("FAIL bubble_count: got %0d expected 100", rq.size()); else n_pass++;
    for (int r = 0; r < 100; r++) begin
      n_checks++; if (rq[r] !== gold[r] || rrq[r] !== RB'(r))
        $display("FAIL bubble_row%0d: res=%0d row=%0d expected res=%0d row=%0d", r, rq[r], rrq[r], gold[r], r); else n_pass++;
    end
    n_checks++; if (bad_rd !== 0 || underflow !== 0)
      $display("FAIL bubble_read_while_empty: got %0d/%0d expected 0/0", bad_rd, underflow); else n_pass++;
    n_checks++; if (rd_cnt !== stream_total) $display("FAIL bubble_reads: got %0d expected %0d", rd_cnt, stream_total); else n_pass++;
  endtask

  task automatic test_backpressure();
    int unsigned k, w0;
    do_reset();
    for (int i = 0; i < 8; i++) push(i + 1, 3, 1);
    for (int i = 0; i < 20; i++) push(1, i + 1, i == 19);
    // First hold: asserted while single-element rows are still in flight.
    k = 0;
    while (rd_cnt < 6 && k < 100) begin @(posedge clk); #2; k++; end
    bus.res_fifo_full = 1'b1;
    w0 = wr_cnt;
    #1;
    n_checks++; if (bus.vec_fifo_read !== 1'b0 || bus.mat_fifo_read !== 1'b0)
      $display("FAIL bp_read_drop1: got %b/%b expected 0/0", bus.vec_fifo_read, bus.mat_fifo_read); else n_pass++;
    repeat (20) @(posedge clk);
    #2;
    n_checks++; if (wr_cnt - w0 > 3) $display("FAIL bp_late_writes: got %0d expected at most 3", wr_cnt - w0); else n_pass++;
    bus.res_fifo_full = 1'b0;
    // Second hold: asserted in the middle of the 20-element row.
    k = 0;
    while (rd_cnt < 16 && k < 100) begin @(posedge clk); #2; k++; end
    bus.res_fifo_full = 1'b1;
    #1;
    n_checks++; if (bus.vec_fifo_read !== 1'b0) $display("FAIL bp_read_drop2: got %b expected 0", bus.vec_fifo_read); else n_pass++;
    repeat (20) @(posedge clk);
    #2;
    bus.res_fifo_full = 1'b0;
    wait_writes(9, 200);
    n_checks++; if (rq.size() !== 9) $display("FAIL bp_count: got %0d expected 9", rq.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rq[i] !== AB'(3 * (i + 1)) || rrq[i] !== RB'(i))
        $display("FAIL bp_single%0d: res=%0d row=%0d expected res=%0d row=%0d", i, rq[i], rrq[i], 3 * (i + 1), i); else n_pass++;
    end
    n_checks++; if (rq[8] !== 40'sd210 || rrq[8] !== 16'd8)
      $display("FAIL bp_long_row: res=%0d row=%0d expected res=210 row=8", rq[8], rrq[8]); else n_pass++;
    n_checks++; if (rd_full !== 0) $display("FAIL bp_read_while_full: got %0d expected 0", rd_full); else n_pass++;
  endtask

  task automatic test_reset_mid_row();
    int unsigned k;
    do_reset();
    push(9, 9, 1); push(2, 2, 1);
    push(1, 5, 0); push(2, 5, 0); push(3, 5, 0); push(4, 5, 1);
    k = 0;
    while (rd_cnt < 4 && k < 100) begin @(posedge clk); #2; k++; end
    @(posedge clk); #2;
    n_checks++; if (bus.res !== 40'd4 || bus.res_row !== 16'd1)
      $display("FAIL midrst_before: res=%0d row=%0d expected res=4 row=1", bus.res, bus.res_row); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.res !== '0 || bus.res_row !== '0 || bus.res_wr_en !== 1'b0 || bus.vec_fifo_read !== 1'b0)
      $display("FAIL midrst_outputs: res=%0d row=%0d wr=%b rd=%b expected 0", bus.res, bus.res_row, bus.res_wr_en, bus.vec_fifo_read); else n_pass++;
    vq.delete(); mq.delete(); lq.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    push(2, 7, 0); push(3, 1, 1);
    wait_writes(1, 50);
    n_checks++; if (rq.size() !== 1) $display("FAIL midrst_count: got %0d expected 1", rq.size()); else n_pass++;
    n_checks++; if (rq[0] !== 40'sd17 || rrq[0] !== 16'd0)
      $display("FAIL midrst_first_row: res=%0d row=%0d expected res=17 row=0", rq[0], rrq[0]); else n_pass++;
  endtask

  task automatic test_overflow();
    int unsigned k;
    logic signed [OAB-1:0] o_exp;
`ifdef ROW_MAC_SAT_EN
    o_exp = 32'sh7FFF_FFFF;
`else
    o_exp = -32'sd262140;
`endif
    do_reset();
    orq.delete();
    o_pushed = o_pushed + 4;
    k = 0;
    while (orq.size() < 1 && k < 50) begin @(posedge clk); k++; end
    @(posedge clk); #2;
    o_pushed = o_pushed + 1;
    k = 0;
    while (orq.size() < 2 && k < 50) begin @(posedge clk); k++; end
    repeat (4) @(posedge clk);
    #2;
    n_checks++; if (orq.size() !== 2) $display("FAIL ovf_count: got %0d expected 2", orq.size()); else n_pass++;
    n_checks++; if (orq[0] !== o_exp) $display("FAIL ovf_res: got %0d expected %0d", orq[0], o_exp); else n_pass++;
    n_checks++; if (orq[1] !== 32'sd1073676289)
      $display("FAIL ovf_next_row: got %0d expected 1073676289", orq[1]); else n_pass++;
  endtask

  initial begin
    #1;
    rst = 1'b0;
    test_reset();
    test_single_row();
    test_back_to_back();
    test_streaming();
    test_bubbles();
    test_backpressure();
    test_reset_mid_row();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
